// File: rtl/booth_seq_multiplier_pkg.sv
// Shared types for the sequential Booth multiplier: FSM state and
// radix-2 Booth recode operation.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OP_NONE = 2'd0,
      OP_ADD  = 2'd1,
      OP_SUB  = 2'd2
   } booth_op_t;

endpackage

// File: rtl/booth_seq_multiplier_if.sv
// Operand/start/done handshake shared by the arithmetic-unit blocks.
// The master side issues operations and the slave side is the arithmetic block.
interface booth_seq_multiplier_if #(
   parameter int WIDTH = 8
);
   logic                   start;
   logic [WIDTH-1:0]       multiplicand;
   logic [WIDTH-1:0]       multiplier;
   logic                   busy;
   logic                   done;
   logic [2*WIDTH-1:0]     product;

   modport master (
      output start, multiplicand, multiplier,
      input  busy, done, product
   );

   modport slave (
      input  start, multiplicand, multiplier,
      output busy, done, product
   );
endinterface

// File: rtl/booth_seq_multiplier_recode.sv
// Radix-2 Booth recoder: maps {Q[0], q_1} to the add/subtract/none step.
module booth_recode
   import mult_pkg::*;
(
   input  logic [1:0] code_i,
   output booth_op_t  op_o
);

   always_comb begin
      op_o = OP_NONE;
      case (code_i)
         2'b01:   op_o = OP_ADD;
         2'b10:   op_o = OP_SUB;
         default: op_o = OP_NONE;
      endcase
   end

endmodule

// File: rtl/booth_seq_multiplier.sv
// Sequential signed multiplier, one Booth recode/add/shift step per clock.
//   state | meaning
//   IDLE  | waiting for start, product holds the last result
//   CALC  | WIDTH recode/add/shift iterations, busy high
//   DONE  | product valid, done pulse; start here chains the next operation
module booth_seq_multiplier
   import mult_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic                    clk,
   input  logic                    reset,
   booth_seq_multiplier_if.slave   bus
);

   state_t               state_q, state_d;
   logic [WIDTH:0]       a_q, a_d;
   logic [WIDTH:0]       m_q, m_d;
   logic [WIDTH-1:0]     q_q, q_d;
   logic                 q1_q, q1_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [2*WIDTH-1:0]   product_q, product_d;

   booth_op_t            op;
   logic [WIDTH:0]       a_sum;
   logic [2*WIDTH+1:0]   shifted;

   booth_recode u_recode (
      .code_i ({q_q[0], q1_q}),
      .op_o   (op)
   );

   // A and M are one bit wider than the operands so A - M cannot overflow
   // when M is the most negative value.
   always_comb begin
      a_sum = a_q;
      case (op)
         OP_ADD:  a_sum = a_q + m_q;
         OP_SUB:  a_sum = a_q - m_q;
         default: a_sum = a_q;
      endcase
      shifted = {a_sum[WIDTH], a_sum, q_q};
   end

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      m_d       = m_q;
      q_d       = q_q;
      q1_d      = q1_q;
      count_d   = count_q;
      product_d = product_q;
      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               a_d     = '0;
               q_d     = bus.multiplier;
               q1_d    = 1'b0;
               m_d     = {bus.multiplicand[WIDTH-1], bus.multiplicand};
               count_d = CNT_W'(WIDTH);
               state_d = CALC;
            end else begin
               state_d = IDLE;
            end
         end
         CALC: begin
            a_d     = shifted[2*WIDTH+1:WIDTH+1];
            q_d     = shifted[WIDTH:1];
            q1_d    = shifted[0];
            count_d = count_q - CNT_W'(1);
            if (count_q == CNT_W'(1)) begin
               state_d   = DONE;
               product_d = {shifted[2*WIDTH:WIDTH+1], shifted[WIDTH:1]};
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         a_q       <= '0;
         m_q       <= '0;
         q_q       <= '0;
         q1_q      <= 1'b0;
         count_q   <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         m_q       <= m_d;
         q_q       <= q_d;
         q1_q      <= q1_d;
         count_q   <= count_d;
         product_q <= product_d;
      end
   end

   assign bus.busy    = (state_q == CALC);
   assign bus.done    = (state_q == DONE);
   assign bus.product = product_q;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Scoreboard bench for the Booth multiplier at WIDTH=8 and WIDTH=16,
// plus a standalone sweep of the recoder.
module tb_booth_seq_multiplier;
   import mult_pkg::*;

   logic clk = 1'b0;
   logic rst_n8, rst_n16;
   always #5 clk = ~clk;

   booth_seq_multiplier_if #(.WIDTH(8))  bus8  ();
   booth_seq_multiplier_if #(.WIDTH(16)) bus16 ();

   booth_seq_multiplier #(.WIDTH(8))  dut8  (.clk(clk), .reset(rst_n8),  .bus(bus8));
   booth_seq_multiplier #(.WIDTH(16)) dut16 (.clk(clk), .reset(rst_n16), .bus(bus16));

   logic [1:0] rc;
   booth_op_t  rop;
   booth_recode u_rec (.code_i(rc), .op_o(rop));

   int n_err = 0;
   int n_checks = 0;
   logic [15:0] q8[$];
   logic [31:0] q16[$];
   logic [15:0] last8 = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] ref8(input logic [7:0] m, input logic [7:0] q);
      logic signed [15:0] r;
      r = $signed(m) * $signed(q);
      return r;
   endfunction

   function automatic logic [31:0] ref16(input logic [15:0] m, input logic [15:0] q);
      logic signed [31:0] r;
      r = $signed(m) * $signed(q);
      return r;
   endfunction

   // Scoreboard pop on every done pulse; product must not move while busy.
   always @(negedge clk) begin
      if (bus8.done) begin
         if (q8.size() == 0) chk("d8_unexpected_done", q8.size(), 1);
         else chk("d8_product", bus8.product, q8.pop_front());
      end
      if (bus8.busy) chk("d8_hold", bus8.product, last8);
      else last8 = bus8.product;
   end

   always @(negedge clk) begin
      if (bus16.done) begin
         if (q16.size() == 0) chk("d16_unexpected_done", q16.size(), 1);
         else chk("d16_product", bus16.product, q16.pop_front());
      end
   end

   task automatic op8(input logic [7:0] m, input logic [7:0] q);
      int n, bc;
      @(posedge clk); #1;
      bus8.start = 1'b1; bus8.multiplicand = m; bus8.multiplier = q;
      q8.push_back(ref8(m, q));
      n = 0; bc = 0;
      do begin
         @(posedge clk); #1;
         if (n == 0) begin
            bus8.start = 1'b0;
            bus8.multiplicand = 8'($urandom);
            bus8.multiplier = 8'($urandom);
         end
         n++;
         if (bus8.busy) bc++;
      end while (!bus8.done && n < 40);
      chk("op8_latency", n, 9);
      chk("op8_busy_cycles", bc, 8);
   endtask

   task automatic drain8();
      int t = 0;
      while (q8.size() != 0 && t < 100) begin @(posedge clk); #1; t++; end
      chk("drain8", q8.size(), 0);
      q8.delete();
   endtask

   task automatic drain16();
      int t = 0;
      while (q16.size() != 0 && t < 100) begin @(posedge clk); #1; t++; end
      chk("drain16", q16.size(), 0);
      q16.delete();
   endtask

   // start held high, operands change every cycle; only every 9th pair is captured.
   task automatic stream8(input int n);
      for (int c = 0; c < n * 9; c++) begin
         @(posedge clk); #1;
         bus8.start = 1'b1;
         bus8.multiplicand = 8'($urandom);
         bus8.multiplier = 8'($urandom);
         if (c % 9 == 0) q8.push_back(ref8(bus8.multiplicand, bus8.multiplier));
      end
      @(posedge clk); #1;
      bus8.start = 1'b0;
      drain8();
   endtask

   task automatic stream16(input int n);
      for (int c = 0; c < n * 17; c++) begin
         @(posedge clk); #1;
         bus16.start = 1'b1;
         bus16.multiplicand = 16'($urandom);
         bus16.multiplier = 16'($urandom);
         if (c % 17 == 0) q16.push_back(ref16(bus16.multiplicand, bus16.multiplier));
      end
      @(posedge clk); #1;
      bus16.start = 1'b0;
      drain16();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      booth_op_t exp_tab [4];
      exp_tab = '{OP_NONE, OP_ADD, OP_SUB, OP_NONE};
      rst_n8 = 1'b0; rst_n16 = 1'b0;
      bus8.start = 1'b0;  bus8.multiplicand = '0;  bus8.multiplier = '0;
      bus16.start = 1'b0; bus16.multiplicand = '0; bus16.multiplier = '0;
      rc = 2'b00;

      #3;
      chk("rst_busy8", bus8.busy, 0);
      chk("rst_done8", bus8.done, 0);
      chk("rst_prod8", bus8.product, 0);
      chk("rst_prod16", bus16.product, 0);

      for (int i = 0; i < 4; i++) begin
         rc = 2'(i);
         #1;
         chk("recode", rop, exp_tab[i]);
      end

      @(posedge clk); #1;
      rst_n8 = 1'b1; rst_n16 = 1'b1;

      op8(8'd3,    8'hFC);
      op8(8'h80,   8'h80);
      op8(8'h7F,   8'h80);
      op8(8'h00,   8'h55);
      op8(8'h55,   8'h00);
      op8(8'hFF,   8'hFF);
      drain8();

      stream8(3);

      // Async reset in CALC cycle 4 aborts without a done pulse.
      @(posedge clk); #1;
      bus8.start = 1'b1; bus8.multiplicand = 8'd37; bus8.multiplier = 8'hEB;
      q8.push_back(ref8(8'd37, 8'hEB));
      @(posedge clk); #1;
      bus8.start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("abort_busy_before", bus8.busy, 1);
      rst_n8 = 1'b0;
      void'(q8.pop_back());
      #1;
      chk("abort_busy", bus8.busy, 0);
      chk("abort_done", bus8.done, 0);
      chk("abort_prod", bus8.product, 0);
      @(posedge clk); #1;
      rst_n8 = 1'b1;
      repeat (15) @(posedge clk);
      #1;
      chk("abort_no_pending", q8.size(), 0);
      op8(8'hE7, 8'd11);
      drain8();

      stream8(1500);
      stream16(1000);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
